// File: rtl/handshake_abc_pkg.sv
// Shared widths and FSM state types for the A->B->C handshake chain.
package handshake_abc_pkg;

  localparam int IN_W    = 16;
  localparam int A_WORDS = 4;
  localparam int C_W     = 8;

  typedef enum logic [1:0] {
    A_COLLECT  = 2'd0,
    A_HOLD     = 2'd1,
    A_WAIT_LOW = 2'd2
  } a_state_t;

  typedef enum logic [1:0] {
    SP_IDLE     = 2'd0,
    SP_ACK      = 2'd1,
    SP_SEND     = 2'd2,
    SP_WAIT_LOW = 2'd3
  } sp_state_t;

endpackage

// File: rtl/hs_splitter.sv
// Four-phase receiver of one IN_W word, re-sent as IN_W/OUT_W four-phase
// transfers of OUT_W bits each, least-significant slice first.
module hs_splitter #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_ready,
  output logic             in_accepted,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ready,
  input  logic             out_accepted
);
  import handshake_abc_pkg::*;

  localparam int N  = IN_W / OUT_W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  sp_state_t        state_reg;
  logic [IN_W-1:0]  buf_reg;
  logic [KW-1:0]    k_reg;
  logic [OUT_W-1:0] words [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_words
    assign words[gi] = buf_reg[gi*OUT_W +: OUT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= SP_IDLE;
      buf_reg     <= '0;
      k_reg       <= '0;
      in_accepted <= 1'b0;
      out_data    <= '0;
      out_ready   <= 1'b0;
    end else begin
      case (state_reg)
        SP_IDLE: begin
          if (in_ready) begin
            buf_reg     <= in_data;
            in_accepted <= 1'b1;
            state_reg   <= SP_ACK;
          end
        end
        SP_ACK: begin
          // First slice goes out as soon as the upstream link is closed.
          if (!in_ready) begin
            in_accepted <= 1'b0;
            k_reg       <= '0;
            out_data    <= words[0];
            out_ready   <= 1'b1;
            state_reg   <= SP_SEND;
          end
        end
        SP_SEND: begin
          if (out_accepted) begin
            out_ready <= 1'b0;
            state_reg <= SP_WAIT_LOW;
          end
        end
        SP_WAIT_LOW: begin
          if (!out_accepted) begin
            if (k_reg == KW'(N-1)) begin
              state_reg <= SP_IDLE;
            end else begin
              k_reg     <= k_reg + 1'b1;
              out_data  <= words[k_reg + 1'b1];
              out_ready <= 1'b1;
              state_reg <= SP_SEND;
            end
          end
        end
        default: state_reg <= SP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/handshake_chain_abc.sv
// Packer (stage A) feeding two hs_splitter stages, ending in a byte stream.
// Optional ABC_PARITY_EN adds parity_c = ^out_c.
module handshake_chain_abc #(
  parameter int IN_W    = handshake_abc_pkg::IN_W,
  parameter int A_WORDS = handshake_abc_pkg::A_WORDS,
  parameter int C_W     = handshake_abc_pkg::C_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    gnt_a,
  input  logic [IN_W-1:0]         in_a,
  input  logic                    accepted_d,
  output logic                    req_a,
  output logic [IN_W*A_WORDS-1:0] out_a,
  output logic                    ready_a,
  output logic [C_W-1:0]          out_c,
  output logic                    ready_c
`ifdef ABC_PARITY_EN
  ,
  output logic                    parity_c
`endif
);
  import handshake_abc_pkg::*;

  localparam int PW    = IN_W * A_WORDS;
  localparam int CNT_W = (A_WORDS > 1) ? $clog2(A_WORDS) : 1;

  a_state_t         a_state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [PW-1:0]    pack_reg;
  logic [PW-1:0]    pack_next;
  logic [PW-1:0]    out_a_reg;
  logic             ready_a_reg;
  logic             req_a_reg;
  logic             accepted_b;
  logic [IN_W-1:0]  word_b;
  logic             ready_b;
  logic             accepted_c;

  // Packet as it would look after capturing in_a into slot cnt_reg.
  for (genvar gi = 0; gi < A_WORDS; gi++) begin : g_slots
    assign pack_next[gi*IN_W +: IN_W] =
      (cnt_reg == CNT_W'(gi)) ? in_a : pack_reg[gi*IN_W +: IN_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_state_reg <= A_COLLECT;
      cnt_reg     <= '0;
      pack_reg    <= '0;
      out_a_reg   <= '0;
      ready_a_reg <= 1'b0;
      req_a_reg   <= 1'b0;
    end else begin
      case (a_state_reg)
        A_COLLECT: begin
          req_a_reg <= start;
          if (req_a_reg && gnt_a) begin
            pack_reg <= pack_next;
            if (cnt_reg == CNT_W'(A_WORDS-1)) begin
              cnt_reg     <= '0;
              out_a_reg   <= pack_next;
              ready_a_reg <= 1'b1;
              req_a_reg   <= 1'b0;
              a_state_reg <= A_HOLD;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        A_HOLD: begin
          if (accepted_b) begin
            ready_a_reg <= 1'b0;
            a_state_reg <= A_WAIT_LOW;
          end
        end
        A_WAIT_LOW: begin
          if (!accepted_b) begin
            req_a_reg   <= start;
            a_state_reg <= A_COLLECT;
          end
        end
        default: a_state_reg <= A_COLLECT;
      endcase
    end
  end

  assign req_a   = req_a_reg;
  assign out_a   = out_a_reg;
  assign ready_a = ready_a_reg;

  hs_splitter #(.IN_W(PW), .OUT_W(IN_W)) u_stage_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (out_a_reg),
    .in_ready     (ready_a_reg),
    .in_accepted  (accepted_b),
    .out_data     (word_b),
    .out_ready    (ready_b),
    .out_accepted (accepted_c)
  );

  hs_splitter #(.IN_W(IN_W), .OUT_W(C_W)) u_stage_c (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (word_b),
    .in_ready     (ready_b),
    .in_accepted  (accepted_c),
    .out_data     (out_c),
    .out_ready    (ready_c),
    .out_accepted (accepted_d)
  );

`ifdef ABC_PARITY_EN
  // out_c is a register, so this tracks it cycle for cycle and resets to 0.
  assign parity_c = ^out_c;
`endif

endmodule

// File: tb/tb_handshake_chain_abc.sv
// Directed + randomized bench for handshake_chain_abc with a byte-queue model.
module tb_handshake_chain_abc;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        gnt_a;
  logic [15:0] in_a;
  logic        accepted_d;
  logic        req_a;
  logic [63:0] out_a;
  logic        ready_a;
  logic [7:0]  out_c;
  logic        ready_c;
`ifdef ABC_PARITY_EN
  logic        parity_c;
`endif

  int errors = 0;
  int checks = 0;
  bit stall  = 1'b0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
`ifdef ABC_PARITY_EN
  logic       par_q[$];
`endif

  handshake_chain_abc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .gnt_a      (gnt_a),
    .in_a       (in_a),
    .accepted_d (accepted_d),
    .req_a      (req_a),
    .out_a      (out_a),
    .ready_a    (ready_a),
    .out_c      (out_c),
    .ready_c    (ready_c)
`ifdef ABC_PARITY_EN
    ,
    .parity_c   (parity_c)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stage D: answers each ready_c at the next negedge unless stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      accepted_d = 1'b0;
    end else if (accepted_d && !ready_c) begin
      accepted_d = 1'b0;
    end else if (!accepted_d && ready_c && !stall) begin
      got_q.push_back(out_c);
`ifdef ABC_PARITY_EN
      par_q.push_back(parity_c);
`endif
      accepted_d = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: packet is the four words concatenated slot 0 lowest; bytes leave low first.
  function automatic logic [63:0] model_packet(input logic [15:0] w [4]);
    return {w[3], w[2], w[1], w[0]};
  endfunction

  task automatic model_bytes(input logic [15:0] w [4]);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(w[i][7:0]);
      exp_q.push_back(w[i][15:8]);
    end
  endtask

  task automatic send_packet(input logic [15:0] w [4], input bit gaps);
    int  n   = 0;
    int  cyc = 0;
    bit  ph  = 1'b1;
    bit  took;
    while (n < 4 && cyc < 200) begin
      @(negedge clk);
      in_a  = w[n];
      gnt_a = gaps ? ph : 1'b1;
      ph    = ~ph;
      if (gaps) check($sformatf("gap_req_a_w%0d_c%0d", n, cyc), 64'(req_a), 64'd1);
      took = req_a && gnt_a;
      @(posedge clk);
      if (took) n++;
      cyc++;
    end
    check("send_done", 64'(n), 64'd4);
    @(negedge clk);
    gnt_a = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int limit);
    int c = 0;
    while (got_q.size() < n && c < limit) begin
      @(negedge clk);
      #1;
      c++;
    end
    check($sformatf("byte_wait_%0d", n), 64'(got_q.size() >= n), 64'd1);
  endtask

  task automatic wait_ready_c(input int limit);
    int c = 0;
    while (!ready_c && c < limit) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("ready_c_wait", 64'(ready_c), 64'd1);
  endtask

  task automatic compare_bytes(input string tag);
    repeat (20) @(negedge clk);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
`ifdef ABC_PARITY_EN
      check($sformatf("%s_par%0d", tag, i), 64'(par_q[i]), 64'(^exp_q[i]));
`endif
    end
  endtask

  task automatic clear_queues();
    got_q.delete();
    exp_q.delete();
`ifdef ABC_PARITY_EN
    par_q.delete();
`endif
  endtask

  initial begin
    logic [15:0] w0 [4];
    logic [15:0] p1 [4];
    logic [15:0] p2 [4];
    logic [7:0]  first_b;

    rst_n = 1'b0;
    start = 1'b1;
    gnt_a = 1'b0;
    in_a  = '0;
    w0    = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};

    // Reset held with start=1
    repeat (3) @(negedge clk);
    check("rst_req_a",   64'(req_a),   64'd0);
    check("rst_ready_a", 64'(ready_a), 64'd0);
    check("rst_ready_c", 64'(ready_c), 64'd0);
    check("rst_out_c",   64'(out_c),   64'd0);
    rst_n = 1'b1;

    // Full packet, fixed data
    clear_queues();
    model_bytes(w0);
    send_packet(w0, 1'b0);
    check("full_ready_a", 64'(ready_a), 64'd1);
    check("full_out_a", out_a, model_packet(w0));
    check("full_out_a_const", out_a, 64'h0718_E5F6_C3D4_A1B2);
    wait_bytes(8, 300);
    compare_bytes("full");
`ifdef ABC_PARITY_EN
    check("par_b2", 64'(par_q[0]), 64'd0);
    check("par_a1", 64'(par_q[1]), 64'd1);
`endif

    // Grant gaps on the same data
    clear_queues();
    model_bytes(w0);
    send_packet(w0, 1'b1);
    check("gap_out_a", out_a, model_packet(w0));
    wait_bytes(8, 300);
    compare_bytes("gap");

    // Backpressure: two random packets while stage D stalls
    clear_queues();
    for (int i = 0; i < 4; i++) begin
      p1[i] = 16'($urandom);
      p2[i] = 16'($urandom);
    end
    model_bytes(p1);
    model_bytes(p2);
    first_b = exp_q[0];
    stall = 1'b1;
    send_packet(p1, 1'b0);
    send_packet(p2, 1'b0);
    wait_ready_c(100);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("stall_ready_c_%0d", c), 64'(ready_c), 64'd1);
      check($sformatf("stall_out_c_%0d", c), 64'(out_c), 64'(first_b));
    end
    stall = 1'b0;
    wait_bytes(16, 600);
    compare_bytes("bp");

    // Reset during the third byte, then a fresh packet
    clear_queues();
    for (int i = 0; i < 4; i++) p1[i] = 16'($urandom);
    send_packet(p1, 1'b0);
    wait_bytes(2, 300);
    stall = 1'b1;
    wait_ready_c(100);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_a",   64'(req_a),   64'd0);
    check("mid_rst_ready_a", 64'(ready_a), 64'd0);
    check("mid_rst_out_a",   out_a,        64'd0);
    check("mid_rst_ready_c", 64'(ready_c), 64'd0);
    check("mid_rst_out_c",   64'(out_c),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    clear_queues();
    for (int i = 0; i < 4; i++) p2[i] = 16'($urandom);
    model_bytes(p2);
    send_packet(p2, 1'b0);
    check("post_rst_out_a", out_a, model_packet(p2));
    wait_bytes(8, 300);
    compare_bytes("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
